// File: rtl/pwm_burst_generator_pkg.sv
// Shared definitions for the PWM/burst generator: channel state encoding
// and the helper that derives the idle output level from the polarity.
package pwm_burst_generator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chState_e;

  function automatic logic inactiveLevel(input logic polarity);
    return ~polarity;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active period and on-time registers, tick-driven
// period counter, burst countdown and the IDLE/RUN state machine.
// Active values are only swapped at start-up or on a period wrap, so a
// reprogrammed channel never emits a truncated or stretched pulse.
module pwm_channel
  import pwm_burst_generator_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int BURST_W  = 8,
  parameter bit POLARITY = 1'b1
) (
  input  logic               ClkIn,
  input  logic               Rst,
  input  logic               tick_i,
  input  logic               enable_i,
  input  logic               load_i,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [CNT_W-1:0]   onTime_i,
  input  logic               burstMode_i,
  input  logic [BURST_W-1:0] burstCount_i,
  output logic               pwm_o,
  output logic               periodEnd_o,
  output logic               busy_o
);

  localparam logic ACTIVE   = POLARITY;
  localparam logic INACTIVE = inactiveLevel(POLARITY);

  chState_e           state_q, state_d;
  logic               enPrev_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   perShadow_q, perShadow_d;
  logic [CNT_W-1:0]   onShadow_q, onShadow_d;
  logic [BURST_W-1:0] burstShadow_q, burstShadow_d;
  logic [CNT_W-1:0]   perAct_q, perAct_d;
  logic [CNT_W-1:0]   onAct_q, onAct_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic               pwm_q, pwm_d;
  logic               periodEnd_q, periodEnd_d;

  // Next-state logic: a Load in the same clock as a start or a wrap is
  // forwarded straight into the active registers so it is never lost.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    perShadow_d   = load_i ? period_i     : perShadow_q;
    onShadow_d    = load_i ? onTime_i     : onShadow_q;
    burstShadow_d = load_i ? burstCount_i : burstShadow_q;
    perAct_d      = perAct_q;
    onAct_d       = onAct_q;
    remaining_d   = remaining_q;
    periodEnd_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i && !enPrev_q) begin
          state_d     = RUN;
          cnt_d       = '0;
          perAct_d    = perShadow_d;
          onAct_d     = onShadow_d;
          remaining_d = (burstShadow_d == '0) ? BURST_W'(1) : burstShadow_d;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == perAct_q) begin
            cnt_d       = '0;
            periodEnd_d = 1'b1;
            perAct_d    = perShadow_d;
            onAct_d     = onShadow_d;
            if (burstMode_i) begin
              if (remaining_q == BURST_W'(1)) begin
                state_d = IDLE;
              end else begin
                remaining_d = remaining_q - BURST_W'(1);
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    pwm_d = ((state_d == RUN) && (cnt_d < onAct_d)) ? ACTIVE : INACTIVE;
  end

  // State, counter and output registers; reset forces the idle level.
  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst) begin
      state_q       <= IDLE;
      enPrev_q      <= 1'b0;
      cnt_q         <= '0;
      perShadow_q   <= '0;
      onShadow_q    <= '0;
      burstShadow_q <= '0;
      perAct_q      <= '0;
      onAct_q       <= '0;
      remaining_q   <= '0;
      pwm_q         <= INACTIVE;
      periodEnd_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      enPrev_q      <= enable_i;
      cnt_q         <= cnt_d;
      perShadow_q   <= perShadow_d;
      onShadow_q    <= onShadow_d;
      burstShadow_q <= burstShadow_d;
      perAct_q      <= perAct_d;
      onAct_q       <= onAct_d;
      remaining_q   <= remaining_d;
      pwm_q         <= pwm_d;
      periodEnd_q   <= periodEnd_d;
    end
  end

  assign pwm_o       = pwm_q;
  assign periodEnd_o = periodEnd_q;
  assign busy_o      = (state_q == RUN);

endmodule

// File: rtl/pwm_burst_generator.sv
// Multi-channel PWM/tone generator: one shared prescaler producing the
// time-base tick and NCH independent channels fed from flat buses.
module pwm_burst_generator
  import pwm_burst_generator_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CNT_W    = 16,
  parameter int PRESC_W  = 8,
  parameter int BURST_W  = 8,
  parameter bit POLARITY = 1'b1
) (
  input  logic                   ClkIn,
  input  logic                   Rst,
  input  logic [PRESC_W-1:0]     Prescale,
  input  logic [NCH-1:0]         Enable,
  input  logic [NCH-1:0]         Load,
  input  logic [NCH*CNT_W-1:0]   Period,
  input  logic [NCH*CNT_W-1:0]   OnTime,
  input  logic [NCH-1:0]         BurstMode,
  input  logic [NCH*BURST_W-1:0] BurstCount,
  output logic [NCH-1:0]         PwmOut,
  output logic [NCH-1:0]         PeriodEnd,
  output logic [NCH-1:0]         Busy
);

  logic [PRESC_W-1:0] prescCnt_q;
  logic               tick;

  assign tick = (prescCnt_q == Prescale);

  // Free-running prescaler; wraps to zero on the clock that raises tick.
  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst) begin
      prescCnt_q <= '0;
    end else if (tick) begin
      prescCnt_q <= '0;
    end else begin
      prescCnt_q <= prescCnt_q + PRESC_W'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : gCh
    pwm_channel #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W),
      .POLARITY(POLARITY)
    ) uChannel (
      .ClkIn       (ClkIn),
      .Rst         (Rst),
      .tick_i      (tick),
      .enable_i    (Enable[i]),
      .load_i      (Load[i]),
      .period_i    (Period[i*CNT_W +: CNT_W]),
      .onTime_i    (OnTime[i*CNT_W +: CNT_W]),
      .burstMode_i (BurstMode[i]),
      .burstCount_i(BurstCount[i*BURST_W +: BURST_W]),
      .pwm_o       (PwmOut[i]),
      .periodEnd_o (PeriodEnd[i]),
      .busy_o      (Busy[i])
    );
  end

endmodule
